// File: rtl/imem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// imem_ctrl_pkg
// Shared constants for the instruction-memory fetch controller.
//   ST_LOAD / ST_RUN / ST_FAULT : controller state encoding (2 bits)
//   INSTR_BYTES                 : bytes per instruction word
//   PC_ALIGN_MASK               : low pc bits that must be zero for a fetch
//   pc_is_aligned()             : word-alignment check on a byte address
// ----------------------------------------------------------------------------
package imem_ctrl_pkg;

    localparam logic [1:0] ST_LOAD  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_FAULT = 2'b10;

    localparam int         INSTR_BYTES   = 4;
    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

    // True when the byte address points at the first byte of a word.
    function automatic logic pc_is_aligned(input logic [31:0] addr);
        return ((addr[1:0] & PC_ALIGN_MASK) == 2'b00);
    endfunction

endpackage

// File: rtl/imem_pc_gen.sv
// ----------------------------------------------------------------------------
// imem_pc_gen
// Combinational next-pc selection for the RUN state.
// Priority: redirect > stall > sequential (pc+4, wrapping at MEM_BYTES).
// A redirect to a misaligned or out-of-range word raises bad_target and
// the pc holds.
// Ports:
//   pc             in  32  current fetch address
//   fetch_stall    in  1   hold request
//   redirect_valid in  1   redirect request
//   redirect_pc    in  32  redirect target byte address
//   next_pc        out 32  pc for the next cycle
//   bad_target     out 1   redirect target is illegal
// ----------------------------------------------------------------------------
module imem_pc_gen
    import imem_ctrl_pkg::*;
#(
    parameter int MEM_BYTES = 32
) (
    input  logic [31:0] pc,
    input  logic        fetch_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] next_pc,
    output logic        bad_target
);

    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);
    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - INSTR_BYTES);

    // Select next pc and flag illegal redirect targets.
    always_comb begin
        next_pc    = pc;
        bad_target = 1'b0;
        if (redirect_valid) begin
            if (pc_is_aligned(redirect_pc) && (redirect_pc <= LAST_WORD)) begin
                next_pc = redirect_pc;
            end else begin
                bad_target = 1'b1;
            end
        end else if (fetch_stall) begin
            next_pc = pc;
        end else begin
            // MEM_BYTES is a power of two, so masking gives the wrap to 0.
            next_pc = (pc + 32'(INSTR_BYTES)) & ADDR_MASK;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl
// Owner of the single-port instruction memory. Boots by writing a program
// byte-serially (LOAD), then sequences the fetch pc (RUN). An illegal
// redirect target parks the controller in FAULT until reset.
// Optional build macro IMEM_RELOAD_EN adds reload_req, which returns RUN or
// FAULT to LOAD.
// Ports:
//   clk, reset (async active-low)
//   reload_req                              (IMEM_RELOAD_EN only)
//   ld_valid/ld_data/ld_last/ld_ready       loader byte stream
//   mem_we/mem_addr/mem_wdata/mem_rdata     memory interface
//   fetch_stall/redirect_valid/redirect_pc  decode-side control
//   pc/instr/instr_valid                    fetch result
//   loading/fault                           status
// ----------------------------------------------------------------------------
module imem_fetch_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int MEM_BYTES = 32,
    parameter int RESET_PC  = 0
) (
    input  logic        clk,
    input  logic        reset,
`ifdef IMEM_RELOAD_EN
    input  logic        reload_req,
`endif
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        fetch_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        loading,
    output logic        fault
);

    localparam logic [31:0] LAST_BYTE = 32'(MEM_BYTES - 1);
    localparam logic [31:0] PC_INIT   = 32'(RESET_PC);

    logic [1:0]  state_r,   state_nxt_s;
    logic [31:0] ld_addr_r, ld_addr_nxt_s;
    logic [31:0] pc_r,      pc_nxt_s;
    logic [31:0] gen_pc_s;
    logic        bad_target_s;
    logic        ld_hs_s;
    logic        reload_s;

`ifdef IMEM_RELOAD_EN
    assign reload_s = reload_req;
`else
    assign reload_s = 1'b0;
`endif

    imem_pc_gen #(
        .MEM_BYTES (MEM_BYTES)
    ) u_pc_gen (
        .pc             (pc_r),
        .fetch_stall    (fetch_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .next_pc        (gen_pc_s),
        .bad_target     (bad_target_s)
    );

    assign ld_hs_s = ld_valid && (state_r == ST_LOAD);

    // Next-state, load-address and pc computation.
    always_comb begin
        state_nxt_s   = state_r;
        ld_addr_nxt_s = ld_addr_r;
        pc_nxt_s      = pc_r;
        case (state_r)
            ST_LOAD: begin
                if (ld_hs_s) begin
                    ld_addr_nxt_s = ld_addr_r + 32'd1;
                    // Filling the last byte ends the load even without ld_last.
                    if (ld_last || (ld_addr_r == LAST_BYTE)) begin
                        state_nxt_s = ST_RUN;
                        pc_nxt_s    = PC_INIT;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    ld_addr_nxt_s = ld_addr_r;
                end
            end
            ST_RUN: begin
                // Reload takes precedence over any redirect in the same cycle.
                if (reload_s) begin
                    state_nxt_s   = ST_LOAD;
                    ld_addr_nxt_s = 32'd0;
                    pc_nxt_s      = PC_INIT;
                end else if (bad_target_s) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    pc_nxt_s = gen_pc_s;
                end
            end
            ST_FAULT: begin
                if (reload_s) begin
                    state_nxt_s   = ST_LOAD;
                    ld_addr_nxt_s = 32'd0;
                    pc_nxt_s      = PC_INIT;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            default: begin
                state_nxt_s   = ST_LOAD;
                ld_addr_nxt_s = 32'd0;
                pc_nxt_s      = PC_INIT;
            end
        endcase
    end

    // State registers; reset restarts the boot load from address 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_LOAD;
            ld_addr_r <= 32'd0;
            pc_r      <= PC_INIT;
        end else begin
            state_r   <= state_nxt_s;
            ld_addr_r <= ld_addr_nxt_s;
            pc_r      <= pc_nxt_s;
        end
    end

    assign ld_ready    = (state_r == ST_LOAD);
    assign loading     = (state_r == ST_LOAD);
    assign instr_valid = (state_r == ST_RUN);
    assign fault       = (state_r == ST_FAULT);
    assign mem_we      = ld_hs_s;
    assign mem_wdata   = ld_data;
    assign mem_addr    = (state_r == ST_LOAD) ? ld_addr_r : pc_r;
    assign pc          = pc_r;
    assign instr       = mem_rdata;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Directed bench for imem_fetch_ctrl with a 32-byte behavioural memory.
// Define IMEM_RELOAD_EN to also exercise reload_req.
// ----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        reload_req;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_rdata;
    logic        fetch_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        loading;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:31];
    logic [4:0] a0_s, a1_s, a2_s, a3_s;

    imem_fetch_ctrl #(
        .MEM_BYTES (32),
        .RESET_PC  (0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
`ifdef IMEM_RELOAD_EN
        .reload_req     (reload_req),
`endif
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .ld_ready       (ld_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .fetch_stall    (fetch_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .loading        (loading),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: byte write on clock, little-endian word read.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[4:0]] <= mem_wdata;
    end
    always_comb begin
        a0_s = mem_addr[4:0];
        a1_s = a0_s + 5'd1;
        a2_s = a0_s + 5'd2;
        a3_s = a0_s + 5'd3;
        mem_rdata = {mem[a3_s], mem[a2_s], mem[a1_s], mem[a0_s]};
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ld_valid = 1'b0; ld_last = 1'b0; fetch_stall = 1'b0;
        redirect_valid = 1'b0; reload_req = 1'b0;
        #2;
        check_eq("rst_loading", {31'd0, loading}, 32'd1);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last, input logic [31:0] addr);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        #1;
        check_eq("ld_addr", mem_addr, addr);
        check_eq("ld_mem_we", {31'd0, mem_we}, 32'd1);
        check_eq("ld_wdata", {24'd0, mem_wdata}, {24'd0, d});
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    logic [7:0] prog1 [0:7];

    initial begin
        reset = 1'b0; reload_req = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
        ld_last = 1'b0; fetch_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        prog1[0] = 8'h33; prog1[1] = 8'h03; prog1[2] = 8'h94; prog1[3] = 8'h00;
        prog1[4] = 8'hB3; prog1[5] = 8'h03; prog1[6] = 8'h39; prog1[7] = 8'h41;

        // Reset state
        #2;
        check_eq("reset_ld_ready", {31'd0, ld_ready}, 32'd1);
        check_eq("reset_loading", {31'd0, loading}, 32'd1);
        check_eq("reset_instr_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("reset_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("reset_fault", {31'd0, fault}, 32'd0);
        check_eq("reset_pc", pc, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // 8-byte program terminated by ld_last
        for (int i = 0; i < 8; i++) load_byte(prog1[i], (i == 7), 32'(i));
        check_eq("t1_loading", {31'd0, loading}, 32'd0);
        check_eq("t1_instr_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("t1_pc0", pc, 32'd0);
        check_eq("t1_instr0", instr, 32'h00940333);
        check_eq("t1_mem_we_idle", {31'd0, mem_we}, 32'd0);
        step();
        check_eq("t1_pc4", pc, 32'd4);
        check_eq("t1_instr4", instr, 32'h413903B3);

        // Full 32-byte load without ld_last, then sequential wrap
        do_reset();
        for (int i = 0; i < 32; i++) begin
            if (i == 31) check_eq("t2_still_loading", {31'd0, loading}, 32'd1);
            load_byte(8'(i), 1'b0, 32'(i));
        end
        check_eq("t2_loading", {31'd0, loading}, 32'd0);
        for (int k = 0; k < 9; k++) begin
            check_eq("t2_pc_seq", pc, 32'((k * 4) % 32));
            if (k == 7) check_eq("t2_instr28", instr, 32'h1F1E1D1C);
            step();
        end
        step();
        check_eq("t3_pc8", pc, 32'd8);

        // Stall for three cycles at pc=8
        fetch_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("t3_stall_pc", pc, 32'd8);
            check_eq("t3_stall_instr", instr, 32'h0B0A0908);
        end
        fetch_stall = 1'b0;
        step();
        check_eq("t3_pc12", pc, 32'd12);

        // Redirect beats stall; highest legal target
        redirect_valid = 1'b1; fetch_stall = 1'b1; redirect_pc = 32'd16;
        step();
        check_eq("t4_pc16", pc, 32'd16);
        check_eq("t4_instr16", instr, 32'h13121110);
        fetch_stall = 1'b0; redirect_pc = 32'd28;
        step();
        check_eq("t4_pc28", pc, 32'd28);
        check_eq("t4_fault_ok", {31'd0, fault}, 32'd0);

        // Misaligned redirect faults; fault is sticky and ignores inputs
        redirect_pc = 32'd6;
        step();
        check_eq("t5_fault", {31'd0, fault}, 32'd1);
        check_eq("t5_instr_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("t5_pc_hold", pc, 32'd28);
        check_eq("t5_ld_ready", {31'd0, ld_ready}, 32'd0);
        redirect_valid = 1'b0; ld_valid = 1'b1;
        #1;
        check_eq("t5_no_we", {31'd0, mem_we}, 32'd0);
        step();
        step();
        check_eq("t5_fault_sticky", {31'd0, fault}, 32'd1);
        check_eq("t5_pc_frozen", pc, 32'd28);
        ld_valid = 1'b0;
`ifdef IMEM_RELOAD_EN
        reload_req = 1'b1;
        step();
        reload_req = 1'b0;
        check_eq("rl_loading", {31'd0, loading}, 32'd1);
        check_eq("rl_fault", {31'd0, fault}, 32'd0);
        check_eq("rl_addr", mem_addr, 32'd0);
`endif

        // Out-of-range redirect faults
        do_reset();
        for (int i = 0; i < 4; i++) load_byte((i == 0) ? 8'h13 : 8'h00, (i == 3), 32'(i));
        check_eq("t5b_pc0", pc, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'd32;
        step();
        redirect_valid = 1'b0;
        check_eq("t5b_fault", {31'd0, fault}, 32'd1);
        check_eq("t5b_instr_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("t5b_pc_hold", pc, 32'd0);
        step(); step(); step();
        check_eq("t5b_fault_sticky", {31'd0, fault}, 32'd1);

        // Reset mid-load discards progress; memory is not cleared
        do_reset();
        for (int i = 0; i < 5; i++) load_byte(8'hAA + 8'(i), 1'b0, 32'(i));
        reset = 1'b0;
        #2;
        check_eq("t6_rst_addr", mem_addr, 32'd0);
        check_eq("t6_rst_loading", {31'd0, loading}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        step();
        ld_valid = 1'b0; ld_last = 1'b1; ld_data = 8'hFF;
        #1;
        check_eq("t6_idle_we", {31'd0, mem_we}, 32'd0);
        step();
        ld_last = 1'b0;
        check_eq("t6_idle_loading", {31'd0, loading}, 32'd1);
        check_eq("t6_idle_addr", mem_addr, 32'd0);
        for (int i = 0; i < 4; i++) load_byte(8'hF0 + 8'(i), (i == 3), 32'(i));
        check_eq("t6_pc0", pc, 32'd0);
        check_eq("t6_instr0", instr, 32'hF3F2F1F0);
        step();
        check_eq("t6_instr4", instr, 32'h070605AE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
